// File: rtl/tpm_port_scheduler.sv
// Front end that lets three requesters share one 1rw1r SRAM: per-cycle
// round-robin grant scan, hazard-free port steering and a fixed-latency
// read-return path back to the owning requester.

// One response lane: shows live SRAM data on its response cycle and
// holds the last delivered word otherwise.
module tpm_rsp_lane #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vld,
  input  logic              sel_r,
  input  logic [DATA_W-1:0] rw_dout,
  input  logic [DATA_W-1:0] r_dout,
  output logic [DATA_W-1:0] data
);
  logic [DATA_W-1:0] hold;

  assign data = vld ? (sel_r ? r_dout : rw_dout) : hold;

  // Remember the delivered word so an idle lane keeps showing it
  always_ff @(posedge clk) begin
    if (rst)      hold <= '0;
    else if (vld) hold <= data;
  end
endmodule

module tpm_port_scheduler #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            req_valid,
  output logic [2:0]            req_ready,
  input  logic [2:0]            req_we,
  input  logic [3*ADDR_W-1:0]   req_addr,
  input  logic [3*DATA_W-1:0]   req_wdata,
  output logic [2:0]            rsp_valid,
  output logic [3*DATA_W-1:0]   rsp_data,
  output logic                  sram_rw_valid,
  output logic                  sram_rw_w_en,
  output logic [ADDR_W-1:0]     sram_rw_addr,
  output logic [DATA_W-1:0]     sram_rw_data_in,
  input  logic [DATA_W-1:0]     sram_rw_data_out,
  output logic                  sram_r_valid,
  output logic [ADDR_W-1:0]     sram_r_addr,
  input  logic [DATA_W-1:0]     sram_r_data_out
);
  localparam int NUM_REQ = 3;

  logic [NUM_REQ-1:0][ADDR_W-1:0] addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] wdata;
  assign addr  = req_addr;
  assign wdata = req_wdata;

  logic [1:0]         rr_ptr, rr_nxt, idx, rw_own, r_own;
  logic [NUM_REQ-1:0] gnt, gnt_r;
  logic               rw_busy, r_busy, hit, conflict;

  // Grant scan from rr_ptr: writes need the rw port, reads prefer the
  // r port and fall back to rw. A request that shares an address with an
  // earlier grant this cycle is held back if either side writes.
  always_comb begin
    gnt      = '0;
    gnt_r    = '0;
    rw_busy  = 1'b0;
    r_busy   = 1'b0;
    rw_own   = '0;
    r_own    = '0;
    hit      = 1'b0;
    rr_nxt   = rr_ptr;
    idx      = '0;
    conflict = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = 2'((int'(rr_ptr) + k) % NUM_REQ);
      // r port holder is always a read, so only a write can clash with it
      conflict = (rw_busy && addr[rw_own] == addr[idx] && (req_we[rw_own] || req_we[idx])) ||
                 (r_busy && addr[r_own] == addr[idx] && req_we[idx]);
      if (req_valid[idx] && !conflict) begin
        if (req_we[idx]) begin
          if (!rw_busy) begin
            rw_busy = 1'b1; rw_own = idx; gnt[idx] = 1'b1;
          end
        end else if (!r_busy) begin
          r_busy = 1'b1; r_own = idx; gnt[idx] = 1'b1; gnt_r[idx] = 1'b1;
        end else if (!rw_busy) begin
          rw_busy = 1'b1; rw_own = idx; gnt[idx] = 1'b1;
        end
      end
      if (gnt[idx] && !hit) begin
        hit    = 1'b1;
        rr_nxt = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      end
    end
  end

  assign req_ready       = rst ? '0 : gnt;
  assign sram_rw_valid   = rw_busy & ~rst;
  assign sram_rw_w_en    = sram_rw_valid & req_we[rw_own];
  assign sram_rw_addr    = sram_rw_valid ? addr[rw_own] : '0;
  assign sram_rw_data_in = sram_rw_w_en ? wdata[rw_own] : '0;
  assign sram_r_valid    = r_busy & ~rst;
  assign sram_r_addr     = sram_r_valid ? addr[r_own] : '0;

  // Round-robin pointer: one past the first requester granted this cycle
  always_ff @(posedge clk) begin
    if (rst) rr_ptr <= '0;
    else     rr_ptr <= rr_nxt;
  end

  // Read tags: per-owner valid plus which port carries its data
  logic [RD_LAT-1:0][NUM_REQ-1:0] vld_pipe, sel_pipe;
  logic [NUM_REQ-1:0]             rd_gnt;
  assign rd_gnt = req_ready & ~req_we;

  // Fixed-latency tag shift; reset drops anything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      sel_pipe <= '0;
    end else begin
      vld_pipe[0] <= rd_gnt;
      sel_pipe[0] <= gnt_r;
      for (int s = 1; s < RD_LAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        sel_pipe[s] <= sel_pipe[s-1];
      end
    end
  end

  assign rsp_valid = rst ? '0 : vld_pipe[RD_LAT-1];

  logic [NUM_REQ-1:0][DATA_W-1:0] rsp_lane;
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    tpm_rsp_lane #(.DATA_W(DATA_W)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .vld     (rsp_valid[i]),
      .sel_r   (sel_pipe[RD_LAT-1][i]),
      .rw_dout (sram_rw_data_out),
      .r_dout  (sram_r_data_out),
      .data    (rsp_lane[i])
    );
  end
  assign rsp_data = rsp_lane;
endmodule
